// File: rtl/p_cacheline_adaptor.sv
// rtl/p_cacheline_adaptor.sv - cache line to fixed-length memory burst adaptor
// Optional last-line buffer enabled by defining LINE_BUFFER_EN.
module p_cacheline_adaptor #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int CW         = $clog2(BEATS);
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           count;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [LINE_WIDTH-1:0]   asm_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic [LINE_WIDTH-1:0]   line_commit;
  logic [ADDR_WIDTH-1:0]   aligned;
  logic                    last_beat;
  logic                    buf_hit;
  logic                    wr_hit;

  assign aligned   = pmem_address & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign last_beat = (count == CW'(BEATS - 1));

`ifdef LINE_BUFFER_EN
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_tag;
  assign buf_hit = buf_valid && (buf_tag == aligned);
  assign wr_hit  = buf_valid && (buf_tag == addr_q);
`else
  assign buf_hit = 1'b0;
  assign wr_hit  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (pmem_write)     state_next = WRITE;
             else if (pmem_read) state_next = buf_hit ? DONE : READ;
      READ,
      WRITE: if (mem_resp && last_beat) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final beat merged with the already-assembled beats, committed in one go.
  always_comb begin
    line_commit = asm_q;
    line_commit[count*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      addr_q <= '0;
      line_q <= '0;
      asm_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          count <= '0;
          if (pmem_write) begin
            addr_q <= aligned;
            line_q <= pmem_wdata;
          end else if (pmem_read) begin
            addr_q <= aligned;
          end
        end
        READ: if (mem_resp) begin
          asm_q[count*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
          count <= count + 1'b1;
        end
        WRITE: if (mem_resp) count <= count + 1'b1;
        default: count <= '0;
      endcase
    end
  end

  // Not cleared by reset so an aborted burst leaves the last good line intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == READ && mem_resp && last_beat)
        rdata_q <= line_commit;
      else if (state == WRITE && mem_resp && last_beat && wr_hit)
        rdata_q <= line_q;
    end
  end

`ifdef LINE_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else if (state == READ && mem_resp && last_beat) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_q;
    end
  end
`endif

  assign pmem_resp   = (state == DONE);
  assign mem_read    = (state == READ);
  assign mem_write   = (state == WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = (state == WRITE) ? line_q[count*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  assign pmem_rdata  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// tb/tb_p_cacheline_adaptor.sv - directed self-checking bench for p_cacheline_adaptor
// Buffer-hit steps run only when LINE_BUFFER_EN is defined.
module tb_p_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [63:0]  mem_wdata, mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;

  p_cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111, B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333, B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA, WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC, WD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] G1 = 64'h5555_0000_0000_0001, G2 = 64'h6666_0000_0000_0002;
  localparam logic [63:0] G3 = 64'h7777_0000_0000_0003, G4 = 64'h8888_0000_0000_0004;
  localparam logic [63:0] N1 = 64'h0101_0101_0101_0101, N2 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] N3 = 64'h0303_0303_0303_0303, N4 = 64'h0404_0404_0404_0404;

  initial begin
    logic [63:0]  rbeats [4];
    logic [63:0]  wbeats [4];
    logic         pat [7];
    logic [255:0] line_read1, line_gap, line_final, fline;
    int           bi;

    line_read1 = {B4, B3, B2, B1};
    line_gap   = {G4, G3, G2, G1};
    line_final = {N4, N3, N2, N1};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; pmem_address = '0; pmem_read = 0; pmem_write = 0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 0;
    step(); step();
    chk("rst_pmem_resp", 256'(pmem_resp), 256'(0));
    chk("rst_mem_read", 256'(mem_read), 256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_mem_address", 256'(mem_address), 256'(0));
    chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    chk("rst_pmem_rdata", pmem_rdata, 256'(0));
    rst = 1'b0;
    step();

    // Read 0x1234, back-to-back beats
    rbeats = '{B1, B2, B3, B4};
    pmem_address = 32'h0000_1234; pmem_read = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_mem_read", 256'(mem_read), 256'(1));
      chk("rd_mem_address", 256'(mem_address), 256'(32'h0000_1220));
      chk("rd_no_early_resp", 256'(pmem_resp), 256'(0));
      mem_resp = 1; mem_rdata = rbeats[i];
    end
    step();
    mem_resp = 0; mem_rdata = '0;
    chk("rd_resp_at_5", 256'(pmem_resp), 256'(1));
    chk("rd_mem_read_drop", 256'(mem_read), 256'(0));
    chk("rd_line", pmem_rdata, line_read1);
    pmem_read = 0;
    step();
    chk("rd_resp_one_cycle", 256'(pmem_resp), 256'(0));
    chk("rd_line_hold", pmem_rdata, line_read1);

    // Write to 0x40
    wbeats = '{WA, WB, WC, WD};
    pmem_address = 32'h0000_0040; pmem_wdata = {WD, WC, WB, WA}; pmem_write = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) pmem_wdata = '1;
      chk("wr_mem_write", 256'(mem_write), 256'(1));
      chk("wr_mem_address", 256'(mem_address), 256'(32'h0000_0040));
      chk("wr_beat", 256'(mem_wdata), 256'(wbeats[i]));
      mem_resp = 1;
    end
    step();
    mem_resp = 0;
    chk("wr_mem_write_drop", 256'(mem_write), 256'(0));
    chk("wr_resp", 256'(pmem_resp), 256'(1));
    chk("wr_rdata_untouched", pmem_rdata, line_read1);
    pmem_write = 0; pmem_wdata = '0;
    step();
    chk("wr_single_resp", 256'(pmem_resp), 256'(0));

    // Read with gaps 1,0,1,1,0,0,1
    pmem_address = 32'h0000_0300; pmem_read = 1;
    rbeats = '{G1, G2, G3, G4};
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("gap_mem_read", 256'(mem_read), 256'(1));
      chk("gap_no_resp", 256'(pmem_resp), 256'(0));
      mem_resp = pat[i];
      if (pat[i]) begin
        mem_rdata = rbeats[bi];
        bi++;
      end else begin
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
    step();
    mem_resp = 0;
    chk("gap_resp", 256'(pmem_resp), 256'(1));
    chk("gap_line", pmem_rdata, line_gap);
    pmem_read = 0;
    step();

    // Simultaneous read and write at 0x80: write wins
    fline = {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
             64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1};
    pmem_address = 32'h0000_0080; pmem_wdata = fline; pmem_read = 1; pmem_write = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("both_no_mem_read", 256'(mem_read), 256'(0));
      chk("both_mem_write", 256'(mem_write), 256'(1));
      chk("both_beat", 256'(mem_wdata), fline[i*64 +: 64]);
      mem_resp = 1;
    end
    step();
    mem_resp = 0;
    chk("both_resp", 256'(pmem_resp), 256'(1));
    chk("both_line_untouched", pmem_rdata, line_gap);
    pmem_read = 0; pmem_write = 0;
    step();

    // Reset after two read beats
    pmem_address = 32'h0000_0500; pmem_read = 1;
    step(); mem_resp = 1; mem_rdata = 64'h9999_9999_9999_9999;
    step(); mem_rdata = 64'hAAAA_0000_AAAA_0000;
    step(); mem_resp = 0; rst = 1; pmem_read = 0;
    step();
    chk("mrst_mem_read", 256'(mem_read), 256'(0));
    chk("mrst_no_resp", 256'(pmem_resp), 256'(0));
    rst = 0;
    step();
    chk("mrst_rdata_kept", pmem_rdata, line_gap);
    chk("mrst_idle_resp", 256'(pmem_resp), 256'(0));
    chk("mrst_idle_read", 256'(mem_read), 256'(0));

    // Following read completes normally
    rbeats = '{N1, N2, N3, N4};
    pmem_address = 32'h0000_1234; pmem_read = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_resp = 1; mem_rdata = rbeats[i];
    end
    step();
    mem_resp = 0;
    chk("post_rst_resp", 256'(pmem_resp), 256'(1));
    chk("post_rst_line", pmem_rdata, line_final);
    pmem_read = 0;
    step();

`ifdef LINE_BUFFER_EN
    // Repeat read of the buffered line
    pmem_address = 32'h0000_1220; pmem_read = 1;
    step();
    chk("buf_hit_resp", 256'(pmem_resp), 256'(1));
    chk("buf_hit_no_mem_read", 256'(mem_read), 256'(0));
    chk("buf_hit_line", pmem_rdata, line_final);
    pmem_read = 0;
    step();

    // Write to buffered line, then read it back
    pmem_address = 32'h0000_1220; pmem_wdata = {WA, WB, WC, WD}; pmem_write = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_resp = 1;
    end
    step();
    mem_resp = 0;
    chk("buf_wr_resp", 256'(pmem_resp), 256'(1));
    pmem_write = 0;
    step();
    pmem_read = 1;
    step();
    chk("buf_rd_resp", 256'(pmem_resp), 256'(1));
    chk("buf_rd_no_mem_read", 256'(mem_read), 256'(0));
    chk("buf_rd_line", pmem_rdata, {WA, WB, WC, WD});
    pmem_read = 0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_cacheline_adaptor.md
Name: p_cacheline_adaptor

Overview:
Memory-side responder for the pipelined I-cache and D-cache miss interfaces. It serves cache line requests (pmem_read / pmem_write, pmem_resp) with a full line, and converts each request into a fixed-length beat burst on the physical memory bus. It sits between the cache arbiter and main memory; one transaction is in flight at a time.

Parameters:
BEATS, 4, beats per cache line
BEAT_WIDTH, 64, bits per memory beat
LINE_WIDTH, 256, line width in bits; must equal BEATS*BEAT_WIDTH
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  reset
pmem_address  in  ADDR_WIDTH  cache-side line address
pmem_read  in  1  cache line read request, level, held until pmem_resp
pmem_write  in  1  cache line write request, level, held until pmem_resp
pmem_wdata  in  LINE_WIDTH  line to write
pmem_rdata  out  LINE_WIDTH  assembled read line
pmem_resp  out  1  one-cycle completion pulse
mem_address  out  ADDR_WIDTH  burst base address, line-aligned
mem_read  out  1  burst read request
mem_write  out  1  burst write request
mem_wdata  out  BEAT_WIDTH  current write beat
mem_rdata  in  BEAT_WIDTH  current read beat
mem_resp  in  1  beat valid (read) / beat accepted (write)

Behaviour:
- Reset: clk and rst are as already decided (reset rst, synchronous, active-high; clock clk).
  - While reset is asserted, the state is IDLE and the beat counter is 0.
  - Outputs on reset: pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, pmem_rdata=0.
- States:
  - IDLE: accept a request, then go to READ or WRITE.
  - READ: count beats, then go to DONE.
  - WRITE: count beats, then go to DONE.
  - DONE: return to IDLE.
- IDLE:
  - On pmem_write, latch the address and line, then go to WRITE.
  - Otherwise, on pmem_read, latch the address, then go to READ.
  - Write has priority if both requests are high.
  - The latched address is {pmem_address[ADDR_WIDTH-1:5], 5'b0}.
- READ:
  - mem_read=1 and mem_address=latched address.
  - Each cycle with mem_resp=1 stores mem_rdata into slice [count*64 +: 64] and increments count.
  - Gaps in mem_resp are tolerated.
  - After the beat with count==BEATS-1, go to DONE.
  - mem_read drops in DONE.
- WRITE:
  - mem_write=1 and mem_wdata=latched_line[count*64 +: 64].
  - Each mem_resp advances count.
  - After the beat with count==BEATS-1, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata is stable and holds the line until the next read completes.
  - Next state is IDLE.
  - A request still high in DONE is not re-accepted; the requester drops it on seeing pmem_resp.
- Latency:
  - Minimum read with back-to-back beats: request seen in IDLE at cycle 0, beats at cycles 1..4, pmem_resp at cycle 5.
  - Write has the same timing.
- Count: 2-bit, wraps to 0 on entry to IDLE.
- Reset mid-burst: abandon the transaction; the next cycle is IDLE with no resp. A partially assembled line is not committed to pmem_rdata.
- pmem_address and pmem_wdata changes after acceptance are ignored.
- mem_resp seen in IDLE or DONE is ignored.

Optional Feature:
LINE_BUFFER_EN:
- Defined:
  - Holds a valid bit plus the tag of the last line delivered to pmem_rdata; the valid bit is cleared on reset.
  - A pmem_read in IDLE whose aligned address equals the buffered tag, with valid=1, goes directly to DONE. No memory burst is issued and pmem_resp follows on the next cycle.
  - A completed write to the buffered tag updates the buffer with pmem_wdata and keeps it valid.
  - Any READ completion updates the tag.
- Undefined: every read issues a burst.

Test Plan:
- Read, address 0x0000_1234, memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles:
  - mem_address=0x0000_1220.
  - pmem_rdata={0x4444…, 0x3333…, 0x2222…, 0x1111…}.
  - pmem_resp pulses exactly 5 cycles after the request.
- Write, line 0xDDDD…_CCCC…_BBBB…_AAAA…, to 0x40:
  - mem_wdata sequence is AAAA, BBBB, CCCC, DDDD.
  - mem_write drops after the 4th mem_resp.
  - Single pmem_resp.
- Read with mem_resp gaps (beat pattern 1,0,1,1,0,0,1):
  - Correct line assembled.
  - pmem_resp pulses one cycle after the 4th beat.
- Simultaneous pmem_read and pmem_write at 0x80: a write burst is performed and no mem_read is asserted.
- rst asserted after 2 read beats:
  - mem_read=0 the next cycle and no pmem_resp.
  - pmem_rdata retains its previous line.
  - A following read completes normally.
- With LINE_BUFFER_EN:
  - A repeat read of 0x1220 gives pmem_resp 1 cycle after the request, with no mem_read asserted.
  - After a write to 0x1220, a read returns the written line.
